// File: rtl/if_id_stage.sv
// -----------------------------------------------------------------------------
// if_id_stage
//
// IF/ID pipeline register for the five-stage RISC-V core. It latches the
// fetched instruction and its PC on each accepted fetch and holds them while
// the hazard unit stalls. A flush, or an edge with no valid fetch, loads a NOP
// bubble. The held word is sliced into the register-index, funct and raw
// immediate fields that decode and the immediate extender use in ID.
//
// Optional feature: define IFID_PERF_CNT_EN to build the saturating
// stall/flush cycle counters. When it is undefined, stall_cnt and flush_cnt
// read 0.
//
// Parameters
//   NOP_INSTR      instruction word held for bubbles and after reset
//   RESET_PC       id_pc value after reset
//
// Ports
//   clk            core clock, rising edge
//   rstn           asynchronous active-low reset
//   if_valid       fetch presents a valid instruction
//   if_pc/if_instr fetched PC and instruction word
//   stall          hold ID contents
//   flush          squash ID contents (overrides stall)
//   if_ready       stage accepts fetch this cycle (~stall | flush)
//   id_valid       ID holds a real instruction
//   id_pc/id_pc4   ID PC and PC+4 (wraps modulo 2^32)
//   id_instr       held instruction word
//   id_opcode .. id_jimm  combinational field slices of id_instr
//   stall_cnt      edges with stall=1 and flush=0 (saturating)
//   flush_cnt      edges with flush=1 (saturating)
// -----------------------------------------------------------------------------
module if_id_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_instr,
    input  logic        stall,
    input  logic        flush,
    output logic        if_ready,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_instr,
    output logic [6:0]  id_opcode,
    output logic [4:0]  id_rd,
    output logic [2:0]  id_funct3,
    output logic [4:0]  id_rs1,
    output logic [4:0]  id_rs2,
    output logic [6:0]  id_funct7,
    output logic [4:0]  id_iimm_shamt,
    output logic [11:0] id_iimm,
    output logic [11:0] id_simm,
    output logic [11:0] id_bimm,
    output logic [19:0] id_uimm,
    output logic [19:0] id_jimm,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic        r_valid;
    logic [31:0] r_pc;
    logic [31:0] r_instr;

    // The redirect fetch that follows a flush is accepted, so flush also
    // re-opens the stage while stall is held.
    assign if_ready = ~stall | flush;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else if (flush) begin
            r_valid <= 1'b0;
            r_pc    <= if_pc;
            r_instr <= NOP_INSTR;
        end else if (!stall) begin
            // A missing fetch also loads a bubble, so ID never shows a
            // stale instruction.
            r_valid <= if_valid;
            r_pc    <= if_pc;
            r_instr <= if_valid ? if_instr : NOP_INSTR;
        end
    end

    assign id_valid = r_valid;
    assign id_pc    = r_pc;
    assign id_pc4   = r_pc + 32'd4;
    assign id_instr = r_instr;

    assign id_opcode     = r_instr[6:0];
    assign id_rd         = r_instr[11:7];
    assign id_funct3     = r_instr[14:12];
    assign id_rs1        = r_instr[19:15];
    assign id_rs2        = r_instr[24:20];
    assign id_funct7     = r_instr[31:25];
    assign id_iimm_shamt = r_instr[24:20];
    assign id_iimm       = r_instr[31:20];
    assign id_simm       = {r_instr[31:25], r_instr[11:7]};
    assign id_bimm       = {r_instr[31], r_instr[7], r_instr[30:25], r_instr[11:8]};
    assign id_uimm       = r_instr[31:12];
    assign id_jimm       = {r_instr[31], r_instr[19:12], r_instr[20], r_instr[30:21]};

`ifdef IFID_PERF_CNT_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (flush) begin
                if (r_flush_cnt != 32'hFFFF_FFFF) begin
                    r_flush_cnt <= r_flush_cnt + 32'd1;
                end
            end else if (stall) begin
                if (r_stall_cnt != 32'hFFFF_FFFF) begin
                    r_stall_cnt <= r_stall_cnt + 32'd1;
                end
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
`else
    assign stall_cnt = 32'd0;
    assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
module tb_if_id_stage;

    logic        clk;
    logic        rstn;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        stall;
    logic        flush;
    logic        if_ready;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_pc4;
    logic [31:0] id_instr;
    logic [6:0]  id_opcode;
    logic [4:0]  id_rd;
    logic [2:0]  id_funct3;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic [6:0]  id_funct7;
    logic [4:0]  id_iimm_shamt;
    logic [11:0] id_iimm;
    logic [11:0] id_simm;
    logic [11:0] id_bimm;
    logic [19:0] id_uimm;
    logic [19:0] id_jimm;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    localparam logic [31:0] NOP = 32'h0000_0013;

    if_id_stage dut (
        .clk(clk), .rstn(rstn), .if_valid(if_valid), .if_pc(if_pc),
        .if_instr(if_instr), .stall(stall), .flush(flush), .if_ready(if_ready),
        .id_valid(id_valid), .id_pc(id_pc), .id_pc4(id_pc4), .id_instr(id_instr),
        .id_opcode(id_opcode), .id_rd(id_rd), .id_funct3(id_funct3),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_funct7(id_funct7),
        .id_iimm_shamt(id_iimm_shamt), .id_iimm(id_iimm), .id_simm(id_simm),
        .id_bimm(id_bimm), .id_uimm(id_uimm), .id_jimm(id_jimm),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic [31:0] sc;
        logic [31:0] fc;
    } exp_t;

    exp_t q[$];

    int n_assert = 0;
    int n_fail   = 0;

    // reference state
    logic        m_v;
    logic [31:0] m_pc, m_instr, m_sc, m_fc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_v = 1'b0; m_pc = 32'h0; m_instr = NOP; m_sc = 32'h0; m_fc = 32'h0;
    endtask

    task automatic check_all(input exp_t e);
        logic [31:0] w;
        w = e.instr;
        chk("id_valid",  {31'b0, id_valid}, {31'b0, e.v});
        chk("id_pc",     id_pc, e.pc);
        chk("id_pc4",    id_pc4, e.pc + 32'd4);
        chk("id_instr",  id_instr, w);
        chk("id_opcode", {25'b0, id_opcode}, {25'b0, w[6:0]});
        chk("id_rd",     {27'b0, id_rd}, {27'b0, w[11:7]});
        chk("id_funct3", {29'b0, id_funct3}, {29'b0, w[14:12]});
        chk("id_rs1",    {27'b0, id_rs1}, {27'b0, w[19:15]});
        chk("id_rs2",    {27'b0, id_rs2}, {27'b0, w[24:20]});
        chk("id_funct7", {25'b0, id_funct7}, {25'b0, w[31:25]});
        chk("id_iimm",   {20'b0, id_iimm}, {20'b0, w[31:20]});
`ifdef IFID_PERF_CNT_EN
        chk("stall_cnt", stall_cnt, e.sc);
        chk("flush_cnt", flush_cnt, e.fc);
`else
        chk("stall_cnt", stall_cnt, 32'h0);
        chk("flush_cnt", flush_cnt, 32'h0);
`endif
    endtask

    // One cycle: drive at negedge, predict and push, pop after the next posedge.
    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic st, input logic fl);
        exp_t e;
        @(negedge clk);
        if_valid = v; if_pc = pc; if_instr = ins; stall = st; flush = fl;
        #1;
        chk("if_ready", {31'b0, if_ready}, {31'b0, (~st | fl)});
        if (fl) begin
            m_v = 1'b0; m_instr = NOP; m_pc = pc;
            if (m_fc != 32'hFFFF_FFFF) m_fc = m_fc + 1;
        end else if (st) begin
            if (m_sc != 32'hFFFF_FFFF) m_sc = m_sc + 1;
        end else begin
            m_v = v; m_pc = pc; m_instr = v ? ins : NOP;
        end
        e.v = m_v; e.pc = m_pc; e.instr = m_instr; e.sc = m_sc; e.fc = m_fc;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            e = q.pop_front();
            check_all(e);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t r;
        rstn = 1'b0; if_valid = 1'b0; if_pc = 32'h0; if_instr = 32'h0;
        stall = 1'b0; flush = 1'b0;
        model_reset();
        #12;
        r.v = 1'b0; r.pc = 32'h0; r.instr = NOP; r.sc = 0; r.fc = 0;
        check_all(r);
        chk("reset_pc4", id_pc4, 32'h4);
        chk("reset_if_ready", {31'b0, if_ready}, 32'h1);
        @(negedge clk);
        rstn = 1'b1;

        // first fetch
        step(1'b1, 32'h100, 32'h0050_0093, 1'b0, 1'b0);
        chk("tp_pc4", id_pc4, 32'h104);
        chk("tp_rd", {27'b0, id_rd}, 32'd1);
        chk("tp_iimm", {20'b0, id_iimm}, 32'h005);
        chk("tp_shamt", {27'b0, id_iimm_shamt}, 32'd5);

        // three-cycle stall, fetch held
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'h104, 32'h00A0_0113, 1'b1, 1'b0);
            chk("stall_hold_instr", id_instr, 32'h0050_0093);
        end
        step(1'b1, 32'h104, 32'h00A0_0113, 1'b0, 1'b0);
        chk("post_stall_instr", id_instr, 32'h00A0_0113);

        // stall and flush together: flush wins
        step(1'b1, 32'h200, 32'h1111_1111, 1'b1, 1'b1);
        chk("flush_instr", id_instr, NOP);
        chk("flush_valid", {31'b0, id_valid}, 32'd0);

        // immediate field mapping
        step(1'b1, 32'h300, 32'hFE00_0EE3, 1'b0, 1'b0);
        chk("bimm", {20'b0, id_bimm}, 32'hFFE);
        step(1'b1, 32'h304, 32'hFFDF_F0EF, 1'b0, 1'b0);
        chk("jimm", {12'b0, id_jimm}, 32'hFFFFE);
        step(1'b1, 32'h308, 32'hFE11_2E23, 1'b0, 1'b0);
        chk("simm", {20'b0, id_simm}, 32'hFFC);
        step(1'b1, 32'h30C, 32'h1234_52B7, 1'b0, 1'b0);
        chk("uimm", {12'b0, id_uimm}, 32'h12345);

        // PC+4 wrap, then a bubble
        step(1'b1, 32'hFFFF_FFFC, 32'h0050_0093, 1'b0, 1'b0);
        chk("pc4_wrap", id_pc4, 32'h0);
        step(1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        chk("bubble_instr", id_instr, NOP);
        chk("bubble_rd", {27'b0, id_rd}, 32'd0);

        // random directed mix
        for (int i = 0; i < 20; i++) begin
            step(1'($urandom_range(0, 1)), $urandom, $urandom,
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 5) == 0));
        end

        // async reset in the middle of a stall
        step(1'b1, 32'h400, 32'h0050_0093, 1'b0, 1'b0);
        step(1'b1, 32'h404, 32'h00A0_0113, 1'b1, 1'b0);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        #1;
        model_reset();
        r.v = 1'b0; r.pc = 32'h0; r.instr = NOP; r.sc = 0; r.fc = 0;
        check_all(r);
        chk("async_pc4", id_pc4, 32'h4);
        @(negedge clk);
        rstn = 1'b1; stall = 1'b0;
        step(1'b1, 32'h500, 32'h0050_0093, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
